// File: rtl/iq_entry_alloc_pkg.sv
// Shared issue-queue constants and types for the entry allocator.
//   IQ_ENT_NUM_DEF : number of issue-queue entries
//   IQ_ENT_SEL_DEF : width of an entry index
//   scan_dir_e     : scan direction for the free-entry priority encoder
package iq_entry_alloc_pkg;

  localparam int unsigned IQ_ENT_NUM_DEF = 16;
  localparam int unsigned IQ_ENT_SEL_DEF = 4;

  typedef enum logic {
    SCAN_LSB = 1'b0,
    SCAN_MSB = 1'b1
  } scan_dir_e;

endpackage

// File: rtl/iq_entry_alloc_if.sv
// Dispatch / issue / recovery signal bundle of the issue-queue entry allocator.
//   slave  : allocator side (iq_entry_alloc)
//   master : dispatch / issue / recovery side
// Signals:
//   stall_DP, invalid1, invalid2          dispatch control
//   iq_entry_num_1/2, allocatable_IQ      entries offered to dispatch
//   free_1/free_num_1, free_2/free_num_2  entry releases from the issue ports
//   prmiss, kill_mask                     misprediction squash
//   free_cnt, dbl_free_err                status
interface iq_entry_alloc_if
  import iq_entry_alloc_pkg::*;
#(
  parameter int unsigned IQ_ENT_NUM = IQ_ENT_NUM_DEF,
  parameter int unsigned IQ_ENT_SEL = IQ_ENT_SEL_DEF
);

  logic                  stall_DP;
  logic                  invalid1;
  logic                  invalid2;
  logic [IQ_ENT_SEL-1:0] iq_entry_num_1;
  logic [IQ_ENT_SEL-1:0] iq_entry_num_2;
  logic                  allocatable_IQ;
  logic                  free_1;
  logic [IQ_ENT_SEL-1:0] free_num_1;
  logic                  free_2;
  logic [IQ_ENT_SEL-1:0] free_num_2;
  logic                  prmiss;
  logic [IQ_ENT_NUM-1:0] kill_mask;
  logic [IQ_ENT_SEL:0]   free_cnt;
  logic                  dbl_free_err;

  modport slave (
    input  stall_DP, invalid1, invalid2,
    input  free_1, free_num_1, free_2, free_num_2,
    input  prmiss, kill_mask,
    output iq_entry_num_1, iq_entry_num_2, allocatable_IQ,
    output free_cnt, dbl_free_err
  );

  modport master (
    output stall_DP, invalid1, invalid2,
    output free_1, free_num_1, free_2, free_num_2,
    output prmiss, kill_mask,
    input  iq_entry_num_1, iq_entry_num_2, allocatable_IQ,
    input  free_cnt, dbl_free_err
  );

endinterface

// File: rtl/iq_find_free.sv
// Positional priority encoder.
//   vec   : request vector (bit i set = candidate i)
//   idx   : lowest (SCAN_LSB) or highest (SCAN_MSB) set index, 0 if none
//   found : at least one bit of vec is set
module iq_find_free
  import iq_entry_alloc_pkg::*;
#(
  parameter int unsigned N   = IQ_ENT_NUM_DEF,
  parameter int unsigned W   = IQ_ENT_SEL_DEF,
  parameter scan_dir_e   DIR = SCAN_LSB
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found
);

  // Walk from the non-preferred end so the last hit is the preferred one.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (DIR == SCAN_LSB) begin
        if (vec[N-1-i]) begin
          idx   = W'(N-1-i);
          found = 1'b1;
        end
      end else begin
        if (vec[i]) begin
          idx   = W'(i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/iq_entry_alloc.sv
// Issue-queue entry allocator.
// Tracks a busy bit per entry and offers two free entries per cycle to the
// dispatch stage: slot 1 gets the lowest-index free entry, slot 2 the
// highest-index free entry. Entries are released by two issue ports and
// squashed in bulk on a misprediction.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : iq_entry_alloc_if.slave (dispatch, frees, squash, status)
module iq_entry_alloc
  import iq_entry_alloc_pkg::*;
#(
  parameter int unsigned IQ_ENT_NUM = IQ_ENT_NUM_DEF,
  parameter int unsigned IQ_ENT_SEL = IQ_ENT_SEL_DEF
) (
  input  logic             clk,
  input  logic             reset,
  iq_entry_alloc_if.slave  bus
);

  logic [IQ_ENT_NUM-1:0] busy_q, busy_nxt, free_vec;
  logic [IQ_ENT_SEL:0]   free_cnt_q, free_cnt_nxt;
  logic                  err_q, err_nxt;
  logic [IQ_ENT_SEL-1:0] num_lo, num_hi;
  logic                  found_lo, found_hi;
  logic                  allocatable;
  logic                  alloc_1, alloc_2;

  assign free_vec = ~busy_q;

  iq_find_free #(.N(IQ_ENT_NUM), .W(IQ_ENT_SEL), .DIR(SCAN_LSB)) u_find_lo (
    .vec   (free_vec),
    .idx   (num_lo),
    .found (found_lo)
  );

  iq_find_free #(.N(IQ_ENT_NUM), .W(IQ_ENT_SEL), .DIR(SCAN_MSB)) u_find_hi (
    .vec   (free_vec),
    .idx   (num_hi),
    .found (found_hi)
  );

  // Two or more free entries guarantees the LSB and MSB picks differ.
  assign allocatable = (free_cnt_q >= (IQ_ENT_SEL+1)'(2));

  assign alloc_1 = allocatable && found_lo && !bus.stall_DP && !bus.invalid1 && !bus.prmiss;
  assign alloc_2 = allocatable && found_hi && !bus.stall_DP && !bus.invalid2 && !bus.prmiss;

  // Clears are applied before sets, so an illegal free of an entry being
  // allocated in the same cycle leaves it busy; the free still flags an
  // error because the entry was not busy when freed.
  always_comb begin
    busy_nxt     = busy_q;
    err_nxt      = err_q;
    free_cnt_nxt = '0;

    if (bus.prmiss) begin
      busy_nxt = busy_nxt & ~bus.kill_mask;
    end
    if (bus.free_1) begin
      if (!busy_q[bus.free_num_1]) err_nxt = 1'b1;
      busy_nxt[bus.free_num_1] = 1'b0;
    end
    if (bus.free_2) begin
      if (!busy_q[bus.free_num_2]) err_nxt = 1'b1;
      busy_nxt[bus.free_num_2] = 1'b0;
    end
    if (alloc_1) busy_nxt[num_lo] = 1'b1;
    if (alloc_2) busy_nxt[num_hi] = 1'b1;

    for (int unsigned i = 0; i < IQ_ENT_NUM; i++) begin
      free_cnt_nxt = free_cnt_nxt + {{IQ_ENT_SEL{1'b0}}, ~busy_nxt[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q     <= '0;
      free_cnt_q <= (IQ_ENT_SEL+1)'(IQ_ENT_NUM);
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_nxt;
      free_cnt_q <= free_cnt_nxt;
      err_q      <= err_nxt;
    end
  end

  assign bus.iq_entry_num_1 = num_lo;
  assign bus.iq_entry_num_2 = num_hi;
  assign bus.allocatable_IQ = allocatable;
  assign bus.free_cnt       = free_cnt_q;
  assign bus.dbl_free_err   = err_q;

endmodule

// File: tb/tb_iq_entry_alloc.sv
// Self-checking bench for iq_entry_alloc: directed scenarios plus a random
// phase, with expected status pushed to a scoreboard queue at drive time and
// popped after the clock edge.
module tb_iq_entry_alloc;
  import iq_entry_alloc_pkg::*;

  localparam int unsigned N = IQ_ENT_NUM_DEF;
  localparam int unsigned S = IQ_ENT_SEL_DEF;

  logic clk = 1'b0;
  logic reset;

  iq_entry_alloc_if #(.IQ_ENT_NUM(N), .IQ_ENT_SEL(S)) bus ();

  iq_entry_alloc #(.IQ_ENT_NUM(N), .IQ_ENT_SEL(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [N-1:0] m_busy = '0;
  logic         m_err  = 1'b0;

  typedef struct {
    logic [S:0]   cnt;
    logic         err;
    logic         al;
    logic         nv;
    logic [S-1:0] n1;
    logic [S-1:0] n2;
  } exp_t;

  exp_t sb[$];

  function automatic int unsigned count_free(input logic [N-1:0] b);
    return $countones(~b);
  endfunction

  function automatic int unsigned lowest_free(input logic [N-1:0] b);
    for (int i = 0; i < int'(N); i++) if (!b[i]) return i;
    return 0;
  endfunction

  function automatic int unsigned highest_free(input logic [N-1:0] b);
    for (int i = int'(N) - 1; i >= 0; i--) if (!b[i]) return i;
    return 0;
  endfunction

  task automatic drive(input logic rst, input logic stall, input logic i1, input logic i2,
                       input logic f1, input int unsigned fn1,
                       input logic f2, input int unsigned fn2,
                       input logic prm, input logic [N-1:0] km);
    reset          = rst;
    bus.stall_DP   = stall;
    bus.invalid1   = i1;
    bus.invalid2   = i2;
    bus.free_1     = f1;
    bus.free_num_1 = S'(fn1);
    bus.free_2     = f2;
    bus.free_num_2 = S'(fn2);
    bus.prmiss     = prm;
    bus.kill_mask  = km;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, '0);
  endtask

  task automatic dispatch_both();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, '0);
  endtask

  // Advance one clock: predict, push, clock, pop and compare.
  task automatic step();
    exp_t         e;
    logic [N-1:0] nb;
    int unsigned  lo, hi, fc;
    logic         go;
    nb = m_busy;
    if (reset) begin
      nb    = '0;
      m_err = 1'b0;
    end else begin
      lo = lowest_free(m_busy);
      hi = highest_free(m_busy);
      go = (count_free(m_busy) >= 2) && !bus.stall_DP && !bus.prmiss;
      if (bus.prmiss) nb = nb & ~bus.kill_mask;
      if (bus.free_1) begin
        if (!m_busy[bus.free_num_1]) m_err = 1'b1;
        nb[bus.free_num_1] = 1'b0;
      end
      if (bus.free_2) begin
        if (!m_busy[bus.free_num_2]) m_err = 1'b1;
        nb[bus.free_num_2] = 1'b0;
      end
      if (go && !bus.invalid1) nb[lo] = 1'b1;
      if (go && !bus.invalid2) nb[hi] = 1'b1;
    end
    m_busy = nb;
    fc     = count_free(nb);
    e.cnt  = (S+1)'(fc);
    e.err  = m_err;
    e.al   = (fc >= 2);
    e.nv   = (fc >= 1);
    e.n1   = S'(lowest_free(nb));
    e.n2   = S'(highest_free(nb));
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sb_free_cnt", 32'(bus.free_cnt), 32'(e.cnt));
    check("sb_dbl_free_err", 32'(bus.dbl_free_err), 32'(e.err));
    check("sb_allocatable", 32'(bus.allocatable_IQ), 32'(e.al));
    if (e.nv) begin
      check("sb_entry_num_1", 32'(bus.iq_entry_num_1), 32'(e.n1));
      check("sb_entry_num_2", 32'(bus.iq_entry_num_2), 32'(e.n2));
    end
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, '0);
    step();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    step();
    check("rst_free_cnt", 32'(bus.free_cnt), 32'd16);
    check("rst_num_1", 32'(bus.iq_entry_num_1), 32'd0);
    check("rst_num_2", 32'(bus.iq_entry_num_2), 32'd15);
    check("rst_allocatable", 32'(bus.allocatable_IQ), 32'd1);
    check("rst_err", 32'(bus.dbl_free_err), 32'd0);

    // Fill the queue from both ends
    for (int i = 0; i < 8; i++) begin
      dispatch_both();
      check("fill_num_1", 32'(bus.iq_entry_num_1), 32'(i));
      check("fill_num_2", 32'(bus.iq_entry_num_2), 32'(15 - i));
      step();
    end
    check("fill_free_cnt", 32'(bus.free_cnt), 32'd0);
    check("fill_allocatable", 32'(bus.allocatable_IQ), 32'd0);

    // Both ports free entry 3 in the same cycle
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3, 1'b1, 3, 1'b0, '0);
    step();
    check("samefree_cnt", 32'(bus.free_cnt), 32'd1);
    check("samefree_err", 32'(bus.dbl_free_err), 32'd0);
    check("samefree_num_1", 32'(bus.iq_entry_num_1), 32'd3);

    // Free 5, then slot 1 alone takes 3, leaving only 5 free
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5, 1'b0, 0, 1'b0, '0);
    step();
    check("two_free_alloc", 32'(bus.allocatable_IQ), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, '0);
    step();
    check("one_free_num_1", 32'(bus.iq_entry_num_1), 32'd5);
    check("one_free_num_2", 32'(bus.iq_entry_num_2), 32'd5);
    dispatch_both();
    step();
    check("one_free_blocked_cnt", 32'(bus.free_cnt), 32'd1);
    check("one_free_blocked_alloc", 32'(bus.allocatable_IQ), 32'd0);

    // Misprediction squash with dispatch active
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, '0);
      step();
    end
    check("pre_kill_cnt", 32'(bus.free_cnt), 32'd6);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 16'h03F0);
    step();
    check("kill_cnt", 32'(bus.free_cnt), 32'd12);
    check("kill_num_1", 32'(bus.iq_entry_num_1), 32'd4);
    check("kill_num_2", 32'(bus.iq_entry_num_2), 32'd15);

    // Stall blocks allocation
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, '0);
    step();
    check("stall_cnt", 32'(bus.free_cnt), 32'd12);

    // Free of an idle entry is sticky
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 7, 1'b0, 0, 1'b0, '0);
    step();
    check("dblfree_err", 32'(bus.dbl_free_err), 32'd1);
    idle();
    for (int i = 0; i < 3; i++) step();
    check("dblfree_sticky", 32'(bus.dbl_free_err), 32'd1);
    check("dblfree_cnt", 32'(bus.free_cnt), 32'd16);

    // Free and allocate the same entry together
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0, '0);
    step();
    check("freealloc_cnt", 32'(bus.free_cnt), 32'd14);
    check("freealloc_num_1", 32'(bus.iq_entry_num_1), 32'd1);
    check("freealloc_err", 32'(bus.dbl_free_err), 32'd1);

    // Slot 2 alone
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, '0);
    step();
    check("slot2_cnt", 32'(bus.free_cnt), 32'd15);
    check("slot2_num_1", 32'(bus.iq_entry_num_1), 32'd0);
    check("slot2_num_2", 32'(bus.iq_entry_num_2), 32'd14);

    // Reset mid-operation overrides frees and dispatch
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7, 1'b0, 0, 1'b0, '0);
    step();
    check("midrst_pre_cnt", 32'(bus.free_cnt), 32'd14);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0, '0);
    step();
    check("midrst_cnt", 32'(bus.free_cnt), 32'd16);
    check("midrst_err", 32'(bus.dbl_free_err), 32'd0);
    check("midrst_num_2", 32'(bus.iq_entry_num_2), 32'd15);

    // Random traffic
    idle();
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] km;
      km = N'($urandom);
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, N - 1),
            $urandom_range(0, 2) == 0, $urandom_range(0, N - 1),
            $urandom_range(0, 19) == 0, km);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
